im2col_sched: RTL and testbench
===============================

Name: im2col_sched

Overview:
- Sequencer for the im2Col datapath.
- On a start command it walks every kernel window position of a feature map in raster order (X fastest, then Y).
- For each window it issues one request (kerWidth, startAddrX, startAddrY, one-cycle dv) to im2Col.
- A credit counter bounds the number of requests in flight; im2Col completions return credits. The parent maps the flat outputs onto the tIm2ColIn fields.

Parameters:
- ADDR_W, 8, width of image dimensions, addresses and stride.
- KER_W, 4, width of the kerWidth field (encoded kernel size minus 1).
- CREDITS, 2, maximum outstanding requests to im2Col; range 1..15.

Ports:
- iClk  in  1  clock; all logic on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iStart  in  1  start pulse; sampled only in IDLE.
- iImgW  in  ADDR_W  image width in pixels; sampled with iStart.
- iImgH  in  ADDR_W  image height in pixels; sampled with iStart.
- iKerWidth  in  KER_W  kernel size minus 1; K = iKerWidth+1; sampled with iStart.
- iStride  in  ADDR_W  window step; 0 is treated as 1; sampled with iStart.
- iAbort  in  1  stop issuing new requests, then drain.
- iColDone  in  1  one-cycle pulse from im2Col per completed request; returns one credit.
- oKerWidth  out  KER_W  latched kernel field, held for the whole job.
- oStartAddrX  out  ADDR_W  window origin X.
- oStartAddrY  out  ADDR_W  window origin Y.
- oDv  out  1  one-cycle request strobe; address outputs are valid when it is high.
- oBusy  out  1  high in every state except IDLE.
- oDone  out  1  one-cycle pulse at job end (normal or aborted).
- oErr  out  1  one-cycle pulse when iStart carries an invalid configuration.

Behaviour:
- Reset values: all outputs 0, state IDLE, credit count 0, X/Y counters 0.
- Reset mid-job: same values on the next edge; in-flight completions arriving later are ignored because the credit count saturates at 0.
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE, when iStart=1:
  - Latch the configuration.
  - If K > iImgW or K > iImgH: pulse oErr the next cycle and stay in IDLE.
  - Otherwise go to ISSUE with X=0, Y=0.
- ISSUE, when credit < CREDITS: drive oDv=1 with oStartAddrX=X, oStartAddrY=Y (registered outputs) and increment credit. Then step the window:
  - If X+stride+K <= imgW: X += stride.
  - Else X = 0; if Y+stride+K <= imgH: Y += stride; else this was the last window, go to DRAIN.
- ISSUE, when credit = CREDITS: oDv=0 and counters hold (stall).
- Arithmetic: window comparisons use ADDR_W+1 bits so the sums cannot overflow.
- First request: oDv rises on the 2nd rising edge after the iStart edge. After that, back-to-back one request per cycle while credit is available.
- Credits: iColDone decrements the count. An issue and an iColDone in the same cycle leave the count unchanged. iColDone when the count is 0 is ignored (no underflow).
- iAbort in ISSUE: no further oDv from the next cycle; go to DRAIN. iAbort in IDLE, DRAIN or FIN has no effect.
- DRAIN: wait for credit = 0, then FIN.
- FIN: pulse oDone for one cycle, return to IDLE.
- iStart outside IDLE is ignored.
- oBusy is deasserted in the cycle oDone is high (FIN → IDLE edge).

Optional Feature:
- Macro: IM2COL_SCHED_PERF_EN.
- When defined:
  - Adds output oStallCnt (32 bits): counts ISSUE cycles with credit = CREDITS.
  - Adds output oIssueCnt (32 bits): counts oDv pulses.
  - Both clear on iRst and on an accepted iStart, and hold value in IDLE.
- When undefined: neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- 6x6 image, iKerWidth=2, iStride=1, iColDone returned 1 cycle after each oDv:
  - exactly 16 oDv pulses at (0,0),(1,0),(2,0),(3,0),(0,1)...(3,3);
  - oDone once; oBusy low afterwards.
- 7x7 image, iKerWidth=2, iStride=2: 9 requests with X,Y ∈ {0,2,4}.
- iStride=0 on a 4x4 image with iKerWidth=3: behaves as stride 1, single request at (0,0).
- CREDITS=2, iColDone held low:
  - exactly 2 oDv pulses, then stall;
  - one iColDone pulse releases exactly one more request;
  - simultaneous oDv and iColDone leave the credit count unchanged.
- iImgW=2, iKerWidth=3 with iStart: oErr pulse, no oDv, oBusy stays 0.
- Interruptions:
  - iAbort after the 3rd request on a 6x6, K=3 job → no 4th oDv; oDone only after the outstanding iColDone pulses return.
  - iRst asserted mid-job → all outputs 0 next cycle; a later stray iColDone causes no change.

Source files
------------

// File: rtl/im2col_sched_if.sv
// im2col_sched_if: request/config bus between a job controller and im2col_sched (IM2COL_SCHED_PERF_EN adds perf counters)
interface im2col_sched_if #(parameter int ADDR_W = 8, parameter int KER_W = 4);
  logic              iStart;
  logic [ADDR_W-1:0] iImgW;
  logic [ADDR_W-1:0] iImgH;
  logic [KER_W-1:0]  iKerWidth;
  logic [ADDR_W-1:0] iStride;
  logic              iAbort;
  logic              iColDone;
  logic [KER_W-1:0]  oKerWidth;
  logic [ADDR_W-1:0] oStartAddrX;
  logic [ADDR_W-1:0] oStartAddrY;
  logic              oDv;
  logic              oBusy;
  logic              oDone;
  logic              oErr;
`ifdef IM2COL_SCHED_PERF_EN
  logic [31:0]       oStallCnt;
  logic [31:0]       oIssueCnt;
  modport slave (input iStart, iImgW, iImgH, iKerWidth, iStride, iAbort, iColDone,
                 output oKerWidth, oStartAddrX, oStartAddrY, oDv, oBusy, oDone, oErr, oStallCnt, oIssueCnt);
  modport master (output iStart, iImgW, iImgH, iKerWidth, iStride, iAbort, iColDone,
                  input oKerWidth, oStartAddrX, oStartAddrY, oDv, oBusy, oDone, oErr, oStallCnt, oIssueCnt);
`else
  modport slave (input iStart, iImgW, iImgH, iKerWidth, iStride, iAbort, iColDone,
                 output oKerWidth, oStartAddrX, oStartAddrY, oDv, oBusy, oDone, oErr);
  modport master (output iStart, iImgW, iImgH, iKerWidth, iStride, iAbort, iColDone,
                  input oKerWidth, oStartAddrX, oStartAddrY, oDv, oBusy, oDone, oErr);
`endif
endinterface

// File: rtl/im2col_sched.sv
// im2col_sched: credit-limited raster walker issuing one im2Col request per kernel window (IM2COL_SCHED_PERF_EN adds stall/issue counters)
module im2col_sched #(
  parameter int ADDR_W  = 8,
  parameter int KER_W   = 4,
  parameter int CREDITS = 2
) (
  input logic iClk,
  input logic iRst,
  im2col_sched_if.slave bus
);
  localparam int AW1 = ADDR_W + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] w_q, w_d, h_q, h_d, stride_q, stride_d;
  logic [ADDR_W-1:0] x_q, x_d, y_q, y_d, ax_q, ax_d, ay_q, ay_d;
  logic [KER_W-1:0]  ker_q, ker_d;
  logic [3:0]        credit_q, credit_d;
  logic              dv_q, dv_d, done_q, done_d, err_q, err_d;
  logic              issue, dec, full, cfg_bad;
  logic [AW1-1:0]    k_new, k_cur, nx, ny;
  assign k_new   = AW1'(bus.iKerWidth) + AW1'(1);
  assign k_cur   = AW1'(ker_q) + AW1'(1);
  assign cfg_bad = (k_new > {1'b0, bus.iImgW}) || (k_new > {1'b0, bus.iImgH});
  assign nx      = {1'b0, x_q} + {1'b0, stride_q} + k_cur;
  assign ny      = {1'b0, y_q} + {1'b0, stride_q} + k_cur;
  assign full    = credit_q >= 4'(CREDITS);
  // next state, window stepping and credit accounting
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    h_d      = h_q;
    stride_d = stride_q;
    ker_d    = ker_q;
    x_d      = x_q;
    y_d      = y_q;
    ax_d     = ax_q;
    ay_d     = ay_q;
    dv_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    issue    = 1'b0;
    case (state_q)
      IDLE: if (bus.iStart) begin
        w_d      = bus.iImgW;
        h_d      = bus.iImgH;
        ker_d    = bus.iKerWidth;
        stride_d = (bus.iStride == '0) ? ADDR_W'(1) : bus.iStride;
        x_d      = '0;
        y_d      = '0;
        err_d    = cfg_bad;
        state_d  = cfg_bad ? IDLE : ISSUE;
      end
      ISSUE: if (bus.iAbort) state_d = DRAIN;
      else if (!full) begin
        issue = 1'b1;
        dv_d  = 1'b1;
        ax_d  = x_q;
        ay_d  = y_q;
        if (nx <= {1'b0, w_q}) x_d = x_q + stride_q;
        else begin
          x_d = '0;
          if (ny <= {1'b0, h_q}) y_d = y_q + stride_q;
          else state_d = DRAIN;
        end
      end
      DRAIN: state_d = (credit_q == '0) ? FIN : DRAIN;
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
    dec      = bus.iColDone && (credit_q != '0 || issue);
    credit_d = credit_q + {3'b0, issue} - {3'b0, dec};
  end
  // state and registered outputs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= IDLE;
      w_q      <= '0;
      h_q      <= '0;
      stride_q <= '0;
      ker_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      credit_q <= '0;
      dv_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      h_q      <= h_d;
      stride_q <= stride_d;
      ker_q    <= ker_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      credit_q <= credit_d;
      dv_q     <= dv_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
  assign bus.oKerWidth   = ker_q;
  assign bus.oStartAddrX = ax_q;
  assign bus.oStartAddrY = ay_q;
  assign bus.oDv         = dv_q;
  assign bus.oBusy       = state_q != IDLE;
  assign bus.oDone       = done_q;
  assign bus.oErr        = err_q;
`ifdef IM2COL_SCHED_PERF_EN
  logic [31:0] stall_cnt_q, issue_cnt_q;
  // stall and issue counters, cleared by reset or an accepted start
  always_ff @(posedge iClk) begin
    if (iRst || (state_q == IDLE && bus.iStart && !cfg_bad)) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + 32'(state_q == ISSUE && full);
      issue_cnt_q <= issue_cnt_q + 32'(issue);
    end
  end
  assign bus.oStallCnt = stall_cnt_q;
  assign bus.oIssueCnt = issue_cnt_q;
`endif
endmodule

// File: tb/tb_im2col_sched.sv
// tb_im2col_sched: randomized scoreboard bench for im2col_sched
module tb_im2col_sched;
  localparam int AW = 8;
  localparam int KW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  im2col_sched_if #(.ADDR_W(AW), .KER_W(KW)) bus ();
  im2col_sched #(.ADDR_W(AW), .KER_W(KW), .CREDITS(2)) dut (.iClk(clk), .iRst(rst), .bus(bus));
  int checks = 0;
  int passes = 0;
  int dv_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int pend = 0;
  bit auto_mode = 0;
  bit rnd_ret = 0;
  logic [19:0] exp_q[$];

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push_job(int w, int h, int k, int s);
    int st = (s == 0) ? 1 : s;
    int kk = k + 1;
    if (kk <= w && kk <= h)
      for (int y = 0; y + kk <= h; y += st)
        for (int x = 0; x + kk <= w; x += st)
          exp_q.push_back({4'(k), 8'(x), 8'(y)});
  endtask

  task automatic start_job(int w, int h, int k, int s);
    @(posedge clk); #1;
    bus.iImgW = 8'(w);
    bus.iImgH = 8'(h);
    bus.iKerWidth = 4'(k);
    bus.iStride = 8'(s);
    bus.iStart = 1'b1;
    push_job(w, h, k, s);
    @(posedge clk); #1;
    bus.iStart = 1'b0;
  endtask

  task automatic wait_done(string nm, int n);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < n) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk(nm, done_cnt - d0, 1);
    chk({nm, "_busy"}, bus.oBusy, 0);
  endtask

  task automatic pulse_done(int cyc);
    @(posedge clk); #1;
    bus.iColDone = 1'b1;
    repeat (cyc) @(posedge clk);
    #1;
    bus.iColDone = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1;
    bus.iAbort = 1'b1;
    @(posedge clk); #1;
    bus.iAbort = 1'b0;
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.oDone) done_cnt++;
      if (bus.oErr) err_cnt++;
      if (bus.oDv) begin
        dv_cnt++;
        if (exp_q.size() == 0) chk("dv_unexpected", 1, 0);
        else chk("window", {bus.oKerWidth, bus.oStartAddrX, bus.oStartAddrY}, exp_q.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (auto_mode) begin
      bus.iColDone = 1'b0;
      if (pend > 0 && (!rnd_ret || $urandom_range(0, 3) != 0)) begin
        bus.iColDone = 1'b1;
        pend--;
      end
      if (bus.oDv) pend++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0, e0, n;
    bus.iStart = 0; bus.iImgW = 0; bus.iImgH = 0; bus.iKerWidth = 0;
    bus.iStride = 0; bus.iAbort = 0; bus.iColDone = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dv", bus.oDv, 0);
    chk("rst_busy", bus.oBusy, 0);
    chk("rst_done", bus.oDone, 0);
    chk("rst_err", bus.oErr, 0);
    chk("rst_x", bus.oStartAddrX, 0);
    chk("rst_y", bus.oStartAddrY, 0);
    chk("rst_ker", bus.oKerWidth, 0);
    rst = 0;

    auto_mode = 1; rnd_ret = 0;
    d0 = dv_cnt;
    start_job(6, 6, 2, 1);
    chk("lat_edge1_dv", bus.oDv, 0);
    chk("lat_edge1_busy", bus.oBusy, 1);
    @(posedge clk); #1;
    chk("lat_edge2_dv", bus.oDv, 1);
    wait_done("job6x6", 400);
    chk("job6x6_count", dv_cnt - d0, 16);
    chk("job6x6_left", exp_q.size(), 0);
    repeat (3) @(posedge clk);

    rnd_ret = 1;
    d0 = dv_cnt;
    start_job(7, 7, 2, 2);
    wait_done("job7x7", 400);
    chk("job7x7_count", dv_cnt - d0, 9);
    repeat (3) @(posedge clk);

    d0 = dv_cnt;
    start_job(4, 4, 3, 0);
    wait_done("stride0", 200);
    chk("stride0_count", dv_cnt - d0, 1);
    repeat (5) @(posedge clk);
    chk("stride0_pend", pend, 0);

    auto_mode = 0; bus.iColDone = 0;
    d0 = dv_cnt; e0 = done_cnt;
    start_job(6, 6, 2, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("credit_stall", dv_cnt - d0, 2);
    pulse_done(1);
    repeat (8) @(posedge clk);
    #1;
    chk("credit_one_more", dv_cnt - d0, 3);
    pulse_done(2);
    repeat (8) @(posedge clk);
    #1;
    chk("credit_simul", dv_cnt - d0, 5);
    pulse_abort();
    repeat (5) @(posedge clk);
    #1;
    chk("drain_no_done", done_cnt - e0, 0);
    chk("drain_busy", bus.oBusy, 1);
    chk("drain_no_dv", dv_cnt - d0, 5);
    pulse_done(2);
    wait_done("credit_job", 50);
    exp_q.delete();

    d0 = dv_cnt; e0 = err_cnt;
    start_job(2, 6, 3, 1);
    chk("err_pulse", bus.oErr, 1);
    chk("err_busy", bus.oBusy, 0);
    @(posedge clk); #1;
    chk("err_one_cycle", bus.oErr, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("err_count", err_cnt - e0, 1);
    chk("err_no_dv", dv_cnt - d0, 0);
    chk("err_busy_after", bus.oBusy, 0);

    auto_mode = 1; rnd_ret = 1;
    d0 = dv_cnt; n = 0;
    start_job(6, 6, 2, 1);
    for (int i = 0; i < 200 && n < 3; i++) begin
      @(posedge clk); #1;
      if (bus.oDv) n++;
      if (n == 3) begin
        bus.iAbort = 1'b1;
        @(posedge clk); #1;
        bus.iAbort = 1'b0;
      end
    end
    wait_done("abort_job", 200);
    chk("abort_count", dv_cnt - d0, 3);
    chk("abort_returned", pend, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);

    rnd_ret = 0;
    start_job(6, 6, 2, 1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1;
    auto_mode = 0;
    @(posedge clk); #1;
    bus.iColDone = 0;
    chk("mid_rst_dv", bus.oDv, 0);
    chk("mid_rst_busy", bus.oBusy, 0);
    chk("mid_rst_x", bus.oStartAddrX, 0);
    chk("mid_rst_y", bus.oStartAddrY, 0);
    chk("mid_rst_ker", bus.oKerWidth, 0);
    chk("mid_rst_done", bus.oDone, 0);
    rst = 0;
    pend = 0;
    exp_q.delete();
    d0 = dv_cnt;
    pulse_done(1);
    repeat (3) @(posedge clk);
    #1;
    chk("stray_busy", bus.oBusy, 0);
    chk("stray_dv", dv_cnt - d0, 0);
    start_job(6, 6, 2, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_credit", dv_cnt - d0, 2);
    pulse_abort();
    pulse_done(2);
    wait_done("post_rst_job", 50);
    exp_q.delete();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
